// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================
// Package  : dmem_pkg
// Purpose  : Shared encodings for the data-memory controller.
// Revision : 1.0
// ============================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int WAIT_STATES_MAX = 15;
    localparam int WAIT_CNT_W      = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================
// Module   : dmem_lane_align
// Purpose  : Alignment check, store byte enables and load extend.
// Revision : 1.0
// ============================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic        o_misalign,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata_lane,
    output logic [31:0] o_rdata_ext
);

    logic [31:0] w_shifted;

    // Addressed lane moved down to bit 0 before extension.
    assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

    always_comb begin
        o_misalign   = 1'b0;
        o_byte_en    = 4'b0000;
        o_wdata_lane = '0;
        o_rdata_ext  = '0;
        case (i_size)
            SIZE_BYTE: begin
                o_byte_en    = 4'b0001 << i_addr_lo;
                o_wdata_lane = {4{i_wdata[7:0]}};
                o_rdata_ext  = i_unsigned ? {24'b0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            SIZE_HALF: begin
                o_misalign = i_addr_lo[0];
                if (!i_addr_lo[0]) begin
                    o_byte_en    = 4'b0011 << i_addr_lo;
                    o_wdata_lane = {2{i_wdata[15:0]}};
                    o_rdata_ext  = i_unsigned ? {16'b0, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
                end
            end
            SIZE_WORD: begin
                o_misalign = |i_addr_lo;
                if (i_addr_lo == 2'b00) begin
                    o_byte_en    = 4'b1111;
                    o_wdata_lane = i_wdata;
                    o_rdata_ext  = i_rword;
                end
            end
            default: o_misalign = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================
// Module   : data_memory_ctrl
// Purpose  : Wait-stated data memory with post-reset clearing.
// Revision : 1.0
// ============================================================
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_m,
    input  logic              we_m,
    input  logic [1:0]        size_m,
    input  logic              unsigned_m,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [31:0]       wdata_m,
    output logic [31:0]       rdata_m,
    output logic              ready_m,
    output logic              misalign_m,
    output logic              init_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);
    localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      clr_idx_q, clr_idx_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  req_we_q, req_we_d;
    size_e                 req_size_q, req_size_d;
    logic                  req_uns_q, req_uns_d;
    logic [1:0]            req_lo_q, req_lo_d;
    logic [IDX_W-1:0]      req_idx_q, req_idx_d;
    logic [31:0]           req_wdata_q, req_wdata_d;

    logic [31:0]      mem [DEPTH];

    logic             w_sel_we, w_sel_uns, w_misalign, w_ready;
    size_e            w_sel_size;
    logic [1:0]       w_sel_lo;
    logic [IDX_W-1:0] w_sel_idx, w_mem_idx;
    logic [31:0]      w_sel_wdata, w_rword, w_wlane, w_rext, w_mem_wdata;
    logic [3:0]       w_be, w_mem_be;
    logic             w_mem_we;
    logic             w_unused_addr;

    // Upper address bits beyond the memory span are ignored by design.
    assign w_unused_addr = ^{1'b0, addr_m};

    // In IDLE the live request feeds the lane logic so a zero-wait store commits on capture.
    assign w_sel_we    = (state_q == ST_IDLE) ? we_m                   : req_we_q;
    assign w_sel_size  = (state_q == ST_IDLE) ? size_e'(size_m)        : req_size_q;
    assign w_sel_uns   = (state_q == ST_IDLE) ? unsigned_m             : req_uns_q;
    assign w_sel_lo    = (state_q == ST_IDLE) ? addr_m[1:0]            : req_lo_q;
    assign w_sel_idx   = (state_q == ST_IDLE) ? addr_m[IDX_W+1:2]      : req_idx_q;
    assign w_sel_wdata = (state_q == ST_IDLE) ? wdata_m                : req_wdata_q;
    assign w_rword     = mem[w_sel_idx];

    dmem_lane_align u_lane_align (
        .i_size       (w_sel_size),
        .i_unsigned   (w_sel_uns),
        .i_addr_lo    (w_sel_lo),
        .i_wdata      (w_sel_wdata),
        .i_rword      (w_rword),
        .o_misalign   (w_misalign),
        .o_byte_en    (w_be),
        .o_wdata_lane (w_wlane),
        .o_rdata_ext  (w_rext)
    );

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        wait_cnt_d  = wait_cnt_q;
        init_done_d = init_done_q;
        req_we_d    = req_we_q;
        req_size_d  = req_size_q;
        req_uns_d   = req_uns_q;
        req_lo_d    = req_lo_q;
        req_idx_d   = req_idx_q;
        req_wdata_d = req_wdata_q;
        w_ready     = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_be    = 4'b0000;
        w_mem_idx   = w_sel_idx;
        w_mem_wdata = w_wlane;
        case (state_q)
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_be    = 4'b1111;
                w_mem_idx   = clr_idx_q;
                w_mem_wdata = '0;
                clr_idx_d   = clr_idx_q + 1'b1;
                if (clr_idx_q == CLR_LAST) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                w_ready = !req_m;
                if (req_m) begin
                    req_we_d    = we_m;
                    req_size_d  = size_e'(size_m);
                    req_uns_d   = unsigned_m;
                    req_lo_d    = addr_m[1:0];
                    req_idx_d   = addr_m[IDX_W+1:2];
                    req_wdata_d = wdata_m;
                    wait_cnt_d  = '0;
                    if (WAIT_STATES == 0) begin
                        state_d  = ST_RESP;
                        w_mem_we = we_m && !w_misalign;
                        w_mem_be = w_be;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d  = ST_RESP;
                    w_mem_we = req_we_q && !w_misalign;
                    w_mem_be = w_be;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                w_ready = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            wait_cnt_q  <= '0;
            init_done_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_size_q  <= SIZE_BYTE;
            req_uns_q   <= 1'b0;
            req_lo_q    <= 2'b00;
            req_idx_q   <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            init_done_q <= init_done_d;
            req_we_q    <= req_we_d;
            req_size_q  <= req_size_d;
            req_uns_q   <= req_uns_d;
            req_lo_q    <= req_lo_d;
            req_idx_q   <= req_idx_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_mem_we && w_mem_be[k]) begin
                mem[w_mem_idx][8*k +: 8] <= w_mem_wdata[8*k +: 8];
            end
        end
    end

    assign ready_m    = w_ready;
    assign init_done  = init_done_q;
    assign misalign_m = (state_q == ST_RESP) && w_misalign;
    assign rdata_m    = (state_q == ST_RESP && !req_we_q && !w_misalign) ? w_rext : 32'h0;

endmodule
`default_nettype wire
